// File: rtl/ddr3_wr_buf_packer_if.sv
// Signal bundle between the JPEG byte source, the write BRAM port A and the
// DDR3 write command engine. The packer sits on the master side.
interface ddr3_wr_buf_packer_if;
    logic [7:0]  i_byte_data;
    logic        i_byte_valid;
    logic        i_frame_end;
    logic        o_byte_ready;
    logic        o_dpb_wr_a_clk;
    logic        o_dpb_wr_a_cea;
    logic        o_dpb_wr_a_wr_en;
    logic [9:0]  o_dpb_wr_a_addr;
    logic [63:0] o_dpb_wr_a_wr_data;
    logic        o_ddr3_master_wr_req;
    logic        o_ddr3_master_wr_frame_down;
    logic [1:0]  o_ddr3_master_wr_buf_rank;
    logic [6:0]  o_ddr3_master_wr_buf_128cnt;
    logic [5:0]  o_ddr3_master_wr_buf_Bytecnt;
    logic        i_ddr3_master_wr_down;

    modport master (
        input  i_byte_data, i_byte_valid, i_frame_end, i_ddr3_master_wr_down,
        output o_byte_ready, o_dpb_wr_a_clk, o_dpb_wr_a_cea, o_dpb_wr_a_wr_en,
               o_dpb_wr_a_addr, o_dpb_wr_a_wr_data, o_ddr3_master_wr_req,
               o_ddr3_master_wr_frame_down, o_ddr3_master_wr_buf_rank,
               o_ddr3_master_wr_buf_128cnt, o_ddr3_master_wr_buf_Bytecnt
    );

    modport slave (
        output i_byte_data, i_byte_valid, i_frame_end, i_ddr3_master_wr_down,
        input  o_byte_ready, o_dpb_wr_a_clk, o_dpb_wr_a_cea, o_dpb_wr_a_wr_en,
               o_dpb_wr_a_addr, o_dpb_wr_a_wr_data, o_ddr3_master_wr_req,
               o_ddr3_master_wr_frame_down, o_ddr3_master_wr_buf_rank,
               o_ddr3_master_wr_buf_128cnt, o_ddr3_master_wr_buf_Bytecnt
    );
endinterface

// File: rtl/ddr3_wr_buf_packer.sv
// Packs the JPEG byte stream into 64-bit words across four 256-word BRAM ranks
// and hands each filled (or frame-terminated) rank to the DDR3 write engine.
module ddr3_wr_buf_packer #(
    parameter int unsigned REQ_LOW_MIN = 2,
    parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
    input logic                  i_pclk,
    input logic                  i_rst,
    ddr3_wr_buf_packer_if.master bus
);
    localparam int unsigned RANKS    = 4;
    localparam int unsigned GAP_W    = 8;
    localparam int unsigned GAP_LAST = (REQ_LOW_MIN > 0) ? REQ_LOW_MIN - 1 : 0;

    typedef struct packed {
        logic       frame_end;
        logic [6:0] cnt128;
        logic [5:0] bytecnt;
    } desc_t;

    typedef enum logic [1:0] {F_FILL, F_PAD, F_PUSH} fill_state_t;
    typedef enum logic [1:0] {R_IDLE, R_REQ, R_GAP} req_state_t;

    fill_state_t      fill_state;
    req_state_t       req_state;
    logic [2:0]       lane;
    logic [63:0]      word_buf;
    logic [7:0]       word_idx;
    logic [3:0]       byte_mod;
    logic [1:0]       fill_rank;
    logic [1:0]       issue_rank;
    logic [2:0]       occ;
    desc_t            queue [RANKS];
    desc_t            pend;
    logic [GAP_W-1:0] gap_cnt;

    logic        byte_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        wr_req;
    logic        frame_down;
    logic [1:0]  buf_rank;
    logic [6:0]  buf_128cnt;
    logic [5:0]  buf_bytecnt;

    logic        accept;
    logic        word_done;
    logic        flush;
    logic        push;
    logic        pop;
    logic [2:0]  occ_nxt;
    logic [63:0] packed_word;

    // Lanes above the current one already hold PAD_BYTE, so the merged word is write-ready.
    always_comb begin
        accept      = bus.i_byte_valid && byte_ready && (fill_state == F_FILL);
        word_done   = accept && (bus.i_frame_end || lane == 3'd7);
        flush       = accept && (bus.i_frame_end || (lane == 3'd7 && word_idx == 8'hFF));
        push        = (fill_state == F_PUSH);
        pop         = (req_state == R_REQ) && bus.i_ddr3_master_wr_down;
        occ_nxt     = occ + 3'(push) - 3'(pop);
        packed_word = word_buf;
        packed_word[{lane, 3'b000} +: 8] = bus.i_byte_data;
    end

    // Fill side: byte packing, pad word, descriptor push.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            fill_state <= F_FILL;
            lane       <= 3'd0;
            word_buf   <= {8{PAD_BYTE}};
            word_idx   <= 8'd0;
            byte_mod   <= 4'd0;
            fill_rank  <= 2'd0;
            occ        <= 3'd0;
            pend       <= '0;
            for (int i = 0; i < RANKS; i++) queue[i] <= '0;
            byte_ready <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= 10'd0;
            wr_data    <= 64'd0;
        end else begin
            wr_en <= 1'b0;
            occ   <= occ_nxt;
            case (fill_state)
                F_FILL: begin
                    byte_ready <= !flush && (occ_nxt != 3'd4);
                    if (accept) begin
                        byte_mod <= byte_mod + 4'd1;
                        if (word_done) begin
                            wr_en    <= 1'b1;
                            wr_addr  <= {fill_rank, word_idx};
                            wr_data  <= packed_word;
                            word_buf <= {8{PAD_BYTE}};
                            lane     <= 3'd0;
                            word_idx <= word_idx + 8'd1;
                        end else begin
                            word_buf <= packed_word;
                            lane     <= lane + 3'd1;
                        end
                    end
                    // byte_mod is (bytes so far - 1) mod 16 once this byte is counted.
                    if (flush) begin
                        pend <= '{frame_end: bus.i_frame_end,
                                  cnt128:    word_idx[7:1],
                                  bytecnt:   {2'b00, byte_mod} + 6'd1};
                        fill_state <= word_idx[0] ? F_PUSH : F_PAD;
                    end
                end
                F_PAD: begin
                    wr_en      <= 1'b1;
                    wr_addr    <= {fill_rank, word_idx};
                    wr_data    <= {8{PAD_BYTE}};
                    byte_ready <= 1'b0;
                    fill_state <= F_PUSH;
                end
                F_PUSH: begin
                    queue[fill_rank] <= pend;
                    fill_rank        <= fill_rank + 2'd1;
                    word_idx         <= 8'd0;
                    byte_mod         <= 4'd0;
                    byte_ready       <= (occ_nxt != 3'd4);
                    fill_state       <= F_FILL;
                end
                default: fill_state <= F_FILL;
            endcase
        end
    end

    // Drain side: level request with a guaranteed low gap between ranks.
    always_ff @(posedge i_pclk) begin
        if (i_rst) begin
            req_state   <= R_IDLE;
            issue_rank  <= 2'd0;
            gap_cnt     <= '0;
            wr_req      <= 1'b0;
            frame_down  <= 1'b0;
            buf_rank    <= 2'd0;
            buf_128cnt  <= 7'd0;
            buf_bytecnt <= 6'd0;
        end else begin
            frame_down <= 1'b0;
            case (req_state)
                R_IDLE: begin
                    if (occ != 3'd0) begin
                        req_state   <= R_REQ;
                        wr_req      <= 1'b1;
                        buf_rank    <= issue_rank;
                        buf_128cnt  <= queue[issue_rank].cnt128;
                        buf_bytecnt <= queue[issue_rank].bytecnt;
                        frame_down  <= queue[issue_rank].frame_end;
                    end
                end
                R_REQ: begin
                    if (bus.i_ddr3_master_wr_down) begin
                        wr_req     <= 1'b0;
                        issue_rank <= issue_rank + 2'd1;
                        gap_cnt    <= '0;
                        req_state  <= R_GAP;
                    end
                end
                R_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_LAST)) req_state <= R_IDLE;
                    else                             gap_cnt   <= gap_cnt + 1'b1;
                end
                default: req_state <= R_IDLE;
            endcase
        end
    end

    assign bus.o_byte_ready                 = byte_ready;
    assign bus.o_dpb_wr_a_clk               = i_pclk;
    assign bus.o_dpb_wr_a_cea               = 1'b1;
    assign bus.o_dpb_wr_a_wr_en             = wr_en;
    assign bus.o_dpb_wr_a_addr              = wr_addr;
    assign bus.o_dpb_wr_a_wr_data           = wr_data;
    assign bus.o_ddr3_master_wr_req         = wr_req;
    assign bus.o_ddr3_master_wr_frame_down  = frame_down;
    assign bus.o_ddr3_master_wr_buf_rank    = buf_rank;
    assign bus.o_ddr3_master_wr_buf_128cnt  = buf_128cnt;
    assign bus.o_ddr3_master_wr_buf_Bytecnt = buf_bytecnt;
endmodule

// File: tb/tb_ddr3_wr_buf_packer.sv
// Directed bench for ddr3_wr_buf_packer: BRAM and request monitor sampled on
// the falling edge, stimulus driven on the falling edge.
module tb_ddr3_wr_buf_packer;
    localparam int unsigned REQ_LOW_MIN = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ddr3_wr_buf_packer_if bus ();

    ddr3_wr_buf_packer #(.REQ_LOW_MIN(REQ_LOW_MIN), .PAD_BYTE(8'h00)) dut (
        .i_pclk(clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int errors  = 0;
    int checks  = 0;
    int send_to = 0;

    logic [63:0] mem [1024];
    int          wr_cnt    = 0;
    logic [9:0]  last_addr = '0;
    int          req_rises = 0;
    logic [1:0]  rr_rank   = '0;
    logic [6:0]  rr_cnt    = '0;
    logic [5:0]  rr_bc     = '0;
    logic        rr_fd     = 1'b0;
    int          last_gap  = 0;
    int          low_run   = 1000;
    int          fd_total  = 0;
    int          fd_orphan = 0;
    logic        req_q     = 1'b0;

    int          w0, r0, f0, mism, t;
    logic [7:0]  b;
    logic [63:0] wtmp;
    logic [7:0]  exp_bytes [256];
    int          lens [3] = '{37, 100, 163};
    int          cnts [3] = '{2, 6, 10};
    int          bcs  [3] = '{5, 4, 3};
    int          nwr  [3] = '{6, 14, 22};

    // BRAM model and request-edge recorder.
    always @(negedge clk) begin
        if (bus.o_dpb_wr_a_wr_en === 1'b1) begin
            mem[bus.o_dpb_wr_a_addr] <= bus.o_dpb_wr_a_wr_data;
            wr_cnt    <= wr_cnt + 1;
            last_addr <= bus.o_dpb_wr_a_addr;
        end
        if (bus.o_ddr3_master_wr_req === 1'b1 && !req_q) begin
            req_rises <= req_rises + 1;
            rr_rank   <= bus.o_ddr3_master_wr_buf_rank;
            rr_cnt    <= bus.o_ddr3_master_wr_buf_128cnt;
            rr_bc     <= bus.o_ddr3_master_wr_buf_Bytecnt;
            rr_fd     <= bus.o_ddr3_master_wr_frame_down;
            last_gap  <= low_run;
        end
        if (bus.o_ddr3_master_wr_req === 1'b1) low_run <= 0;
        else                                   low_run <= low_run + 1;
        if (bus.o_ddr3_master_wr_frame_down === 1'b1) fd_total <= fd_total + 1;
        if (bus.o_ddr3_master_wr_frame_down === 1'b1 && bus.o_ddr3_master_wr_req !== 1'b1)
            fd_orphan <= fd_orphan + 1;
        req_q <= (bus.o_ddr3_master_wr_req === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic fe);
        int k;
        k = 0;
        bus.i_byte_data  = d;
        bus.i_byte_valid = 1'b1;
        bus.i_frame_end  = fe;
        while (bus.o_byte_ready !== 1'b1 && k < 5000) begin
            @(negedge clk);
            k++;
        end
        if (bus.o_byte_ready !== 1'b1) send_to++;
        @(negedge clk);
        bus.i_byte_valid = 1'b0;
        bus.i_frame_end  = 1'b0;
    endtask

    task automatic wait_rises(input int n, input string tag);
        int k;
        k = 0;
        while (req_rises < n && k < 20000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 64'(req_rises), 64'(n));
    endtask

    task automatic pulse_down;
        bus.i_ddr3_master_wr_down = 1'b1;
        @(negedge clk);
        bus.i_ddr3_master_wr_down = 1'b0;
    endtask

    task automatic check_desc(input string tag, input int rank, input int c, input int bc, input int fd);
        chk({tag, "_rank"},  64'(rr_rank), 64'(rank));
        chk({tag, "_128cnt"}, 64'(rr_cnt), 64'(c));
        chk({tag, "_bytecnt"}, 64'(rr_bc), 64'(bc));
        chk({tag, "_fdown"}, 64'(rr_fd),   64'(fd));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"},   64'(bus.o_byte_ready), 64'd1);
        chk({tag, "_wr_en"},   64'(bus.o_dpb_wr_a_wr_en), 64'd0);
        chk({tag, "_addr"},    64'(bus.o_dpb_wr_a_addr), 64'd0);
        chk({tag, "_data"},    bus.o_dpb_wr_a_wr_data, 64'd0);
        chk({tag, "_req"},     64'(bus.o_ddr3_master_wr_req), 64'd0);
        chk({tag, "_fdown"},   64'(bus.o_ddr3_master_wr_frame_down), 64'd0);
        chk({tag, "_rank"},    64'(bus.o_ddr3_master_wr_buf_rank), 64'd0);
        chk({tag, "_128cnt"},  64'(bus.o_ddr3_master_wr_buf_128cnt), 64'd0);
        chk({tag, "_bytecnt"}, 64'(bus.o_ddr3_master_wr_buf_Bytecnt), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_byte_data = 8'd0;
        bus.i_byte_valid = 1'b0;
        bus.i_frame_end = 1'b0;
        bus.i_ddr3_master_wr_down = 1'b0;
        tick(3);
        check_reset("por");
        rst = 1'b0;
        tick(2);

        // Full 2048-byte frame into rank 0.
        w0 = wr_cnt; r0 = req_rises; f0 = fd_total;
        for (int i = 0; i < 2048; i++) send_byte(8'(i), i == 2047);
        wait_rises(r0 + 1, "t1_req");
        chk("t1_writes", 64'(wr_cnt - w0), 64'd256);
        chk("t1_word0", mem[0], 64'h0706050403020100);
        chk("t1_word255", mem[255], 64'hFFFEFDFCFBFAF9F8);
        chk("t1_last_addr", 64'(last_addr), 64'd255);
        check_desc("t1", 0, 127, 16, 1);
        chk("t1_fd_count", 64'(fd_total - f0), 64'd1);
        pulse_down;
        tick(4);

        // 20-byte frame into rank 1: partial word plus pad word.
        w0 = wr_cnt; r0 = req_rises;
        for (int i = 0; i < 20; i++) send_byte(8'(8'hA0 + i), i == 19);
        wait_rises(r0 + 1, "t2_req");
        chk("t2_writes", 64'(wr_cnt - w0), 64'd4);
        chk("t2_word0", mem[256], 64'hA7A6A5A4A3A2A1A0);
        chk("t2_word2", mem[258], 64'h00000000B3B2B1B0);
        chk("t2_pad", mem[259], 64'd0);
        chk("t2_last_addr", 64'(last_addr), 64'd259);
        check_desc("t2", 1, 1, 4, 1);
        pulse_down;
        tick(4);

        // 9-byte frame into rank 2: odd final index, no pad.
        w0 = wr_cnt; r0 = req_rises;
        for (int i = 0; i < 9; i++) send_byte(8'(8'h50 + i), i == 8);
        wait_rises(r0 + 1, "t3_req");
        chk("t3_writes", 64'(wr_cnt - w0), 64'd2);
        chk("t3_word0", mem[512], 64'h5756555453525150);
        chk("t3_word1", mem[513], 64'h0000000000000058);
        chk("t3_last_addr", 64'(last_addr), 64'd513);
        check_desc("t3", 2, 0, 9, 1);
        pulse_down;
        tick(4);

        rst = 1'b1;
        tick(1);
        check_reset("rst2");
        rst = 1'b0;
        tick(1);

        // Four full ranks with a stalled consumer.
        r0 = req_rises; f0 = fd_total;
        for (int i = 0; i < 8192; i++) send_byte(8'(i * 7), 1'b0);
        tick(6);
        chk("t4_ready_low", 64'(bus.o_byte_ready), 64'd0);
        chk("t4_req_high", 64'(bus.o_ddr3_master_wr_req), 64'd1);
        chk("t4_rank", 64'(bus.o_ddr3_master_wr_buf_rank), 64'd0);
        chk("t4_128cnt", 64'(bus.o_ddr3_master_wr_buf_128cnt), 64'd127);
        chk("t4_bytecnt", 64'(bus.o_ddr3_master_wr_buf_Bytecnt), 64'd16);
        chk("t4_one_req", 64'(req_rises - r0), 64'd1);
        chk("t4_no_fd", 64'(fd_total - f0), 64'd0);
        tick(20);
        chk("t4_stall_hold", 64'(bus.o_byte_ready), 64'd0);
        pulse_down;
        t = 0;
        while (bus.o_byte_ready !== 1'b1 && t < 100) begin tick(1); t++; end
        chk("t4_ready_back", 64'(bus.o_byte_ready), 64'd1);
        w0 = wr_cnt;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i), i == 7);
        wait_rises(r0 + 2, "t4_req2");
        check_desc("t4b", 1, 127, 16, 0);
        chk("t4_gap", 64'(last_gap >= int'(REQ_LOW_MIN)), 64'd1);
        tick(6);
        chk("t4_writes", 64'(wr_cnt - w0), 64'd2);
        chk("t4_word0_r0", mem[0], 64'hC7C6C5C4C3C2C1C0);
        chk("t4_pad_r0", mem[1], 64'd0);
        chk("t4_word0_r1", mem[256], 64'h312A231C150E0700);
        pulse_down;
        wait_rises(r0 + 3, "t4_req3");
        check_desc("t4c", 2, 127, 16, 0);
        pulse_down;
        wait_rises(r0 + 4, "t4_req4");
        check_desc("t4d", 3, 127, 16, 0);
        pulse_down;
        wait_rises(r0 + 5, "t4_req5");
        check_desc("t4e", 0, 0, 8, 1);
        pulse_down;
        tick(4);

        // Reset mid-frame with a request outstanding.
        r0 = req_rises;
        for (int i = 0; i < 3; i++) send_byte(8'(i + 1), i == 2);
        wait_rises(r0 + 1, "t5_req");
        check_desc("t5a", 1, 0, 3, 1);
        for (int i = 0; i < 1000; i++) send_byte(8'(i), 1'b0);
        rst = 1'b1;
        tick(1);
        check_reset("t5_rst");
        rst = 1'b0;
        w0 = wr_cnt; r0 = req_rises;
        for (int i = 0; i < 5; i++) send_byte(8'(8'hE0 + i), i == 4);
        wait_rises(r0 + 1, "t5_req2");
        chk("t5_writes", 64'(wr_cnt - w0), 64'd2);
        chk("t5_word0", mem[0], 64'h000000E4E3E2E1E0);
        chk("t5_pad", mem[1], 64'd0);
        chk("t5_last_addr", 64'(last_addr), 64'd1);
        check_desc("t5b", 0, 0, 5, 1);
        pulse_down;
        tick(4);

        // Gappy valid with a lone frame_end inside each frame.
        for (int f = 0; f < 3; f++) begin
            w0 = wr_cnt; r0 = req_rises;
            for (int i = 0; i < lens[f]; i++) begin
                if (i == lens[f] / 2) begin
                    bus.i_frame_end = 1'b1;
                    tick(1);
                    bus.i_frame_end = 1'b0;
                end
                repeat ($urandom_range(0, 2)) tick(1);
                b = 8'($urandom);
                exp_bytes[i] = b;
                send_byte(b, i == lens[f] - 1);
            end
            wait_rises(r0 + 1, "t6_req");
            chk("t6_writes", 64'(wr_cnt - w0), 64'(nwr[f]));
            check_desc("t6", f + 1, cnts[f], bcs[f], 1);
            mism = 0;
            for (int i = 0; i < lens[f]; i++) begin
                wtmp = mem[{2'(f + 1), 8'(i / 8)}];
                if (wtmp[(i % 8) * 8 +: 8] !== exp_bytes[i]) mism++;
            end
            chk("t6_data", 64'(mism), 64'd0);
            pulse_down;
            tick(4);
        end

        r0 = req_rises;
        bus.i_frame_end = 1'b1;
        tick(1);
        bus.i_frame_end = 1'b0;
        tick(20);
        chk("t6_lone_fe", 64'(req_rises - r0), 64'd0);
        chk("t6_req_idle", 64'(bus.o_ddr3_master_wr_req), 64'd0);
        chk("fd_orphan", 64'(fd_orphan), 64'd0);
        chk("send_timeouts", 64'(send_to), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
